// File: rtl/decryption_pkg.sv
// -----------------------------------------------------------------------------
// decryption_pkg
// Shared constants and types for the decryption datapath.
//   SYS_DWIDTH_C  : plaintext byte width
//   MST_DWIDTH_C  : packed word width (four bytes)
//   TERM_CHAR_DEF : default end-of-message character (never stored)
//   entry_t       : one buffered word, {last, be[3:0], data[31:0]}
//   be_from_idx() : byte enables for a partial word holding idx bytes
// -----------------------------------------------------------------------------
package decryption_pkg;

  localparam int SYS_DWIDTH_C = 8;
  localparam int MST_DWIDTH_C = 32;
  localparam logic [SYS_DWIDTH_C-1:0] TERM_CHAR_DEF = 8'hFA;

  typedef struct packed {
    logic                    last;
    logic [3:0]              be;
    logic [MST_DWIDTH_C-1:0] data;
  } entry_t;

  // Bytes fill from the top, so enables grow downward from be[3].
  function automatic logic [3:0] be_from_idx(input logic [1:0] idx);
    logic [3:0] be;
    case (idx)
      2'd0:    be = 4'b0000;
      2'd1:    be = 4'b1000;
      2'd2:    be = 4'b1100;
      default: be = 4'b1110;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/packer_fifo.sv
// -----------------------------------------------------------------------------
// packer_fifo
// Generic synchronous show-ahead FIFO. The head entry is read combinationally
// from storage and forced to zero while the FIFO is empty. Pointers carry one
// extra wrap bit so full and empty are told apart without a separate counter.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear of both pointers (priority over push/pop)
//   push_i     : write wdata_i
//   pop_i      : retire the head entry
//   wdata_i    : write data
//   rdata_o    : head entry (zero when empty)
//   full_o     : DEPTH entries held
//   empty_o    : no entries held
//   level_o    : occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module packer_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_wr_en;
  logic             w_rd_en;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // When full, the write slot equals the head slot; a same-cycle pop has
  // already consumed the head combinationally, so overwriting it is safe.
  assign w_wr_en = push_i && !clr_i && (!w_full || pop_i);
  assign w_rd_en = pop_i  && !clr_i && !w_empty;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always blocks are evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clr_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only ever observed
  // after it has been written, and empty masking hides stale contents.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign full_o  = w_full;
  assign empty_o = w_empty;
  assign level_o = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/plaintext_packer.sv
// -----------------------------------------------------------------------------
// plaintext_packer
// Packs the plaintext byte stream big-endian into 32-bit words and buffers
// them in a show-ahead FIFO for a valid/ready consumer. A terminator byte
// (TERM_CHAR) closes the message: any partial word is flushed with byte
// enables and last=1, or an empty last word is emitted at a word boundary.
// Words that arrive while the FIFO is full (and not popping) are dropped and
// set the sticky overflow flag.
//
// Optional feature: define PLAINTEXT_PACKER_MSG_CNT_EN to add msg_cnt_o, a
// 16-bit wrapping count of accepted last=1 words.
//
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear of accumulator, FIFO, overflow (and count)
//   data_i     : plaintext byte,  valid_i : byte qualifier (no backpressure)
//   data_o     : head word, first byte in [31:24]
//   be_o       : byte enables, be_o[3] <-> [31:24]
//   last_o     : head word ends a message
//   valid_o    : head valid,  ready_i : consumer accepts head
//   level_o    : FIFO occupancy
//   overflow_o : sticky, a word was dropped
//   msg_cnt_o  : (optional) accepted message count
// -----------------------------------------------------------------------------
module plaintext_packer
  import decryption_pkg::*;
#(
  parameter int                    SYS_DWIDTH = SYS_DWIDTH_C,
  parameter int                    MST_DWIDTH = MST_DWIDTH_C,
  parameter int                    FIFO_DEPTH = 8,
  parameter logic [SYS_DWIDTH-1:0] TERM_CHAR  = TERM_CHAR_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr_i,
  input  logic [SYS_DWIDTH-1:0]         data_i,
  input  logic                          valid_i,
  output logic [MST_DWIDTH-1:0]         data_o,
  output logic [3:0]                    be_o,
  output logic                          last_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overflow_o
`ifdef PLAINTEXT_PACKER_MSG_CNT_EN
  ,
  output logic [15:0]                   msg_cnt_o
`endif
);

  logic [1:0]              r_idx;
  logic [3*SYS_DWIDTH-1:0] r_partial;
  logic                    r_overflow;

  logic   w_is_term;
  logic   w_is_byte;
  logic   w_push;
  logic   w_pop;
  logic   w_accept;
  logic   w_full;
  logic   w_empty;
  entry_t w_push_entry;
  entry_t w_head;

  assign w_is_term = valid_i && (data_i == TERM_CHAR);
  assign w_is_byte = valid_i && (data_i != TERM_CHAR);

  // A word leaves the accumulator on the fourth byte or on any terminator.
  assign w_push   = !clr_i && (w_is_term || (w_is_byte && (r_idx == 2'd3)));
  assign w_pop    = !clr_i && !w_empty && ready_i;
  assign w_accept = w_push && (!w_full || w_pop);

  // The partial register is zeroed whenever idx returns to 0, so unused
  // byte lanes of a flushed word are already zero.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_push_entry = '0;
    if (w_is_term) begin
      w_push_entry.data = {r_partial, {SYS_DWIDTH{1'b0}}};
      w_push_entry.be   = be_from_idx(r_idx);
      w_push_entry.last = 1'b1;
    end else begin
      w_push_entry.data = {r_partial, data_i};
      w_push_entry.be   = 4'b1111;
      w_push_entry.last = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= 2'd0;
      r_partial <= '0;
    end else if (clr_i || w_is_term || (w_is_byte && (r_idx == 2'd3))) begin
      // Cleared whether the word was accepted or dropped.
      r_idx     <= 2'd0;
      r_partial <= '0;
    end else if (w_is_byte) begin
      case (r_idx)
        2'd0:    r_partial[3*SYS_DWIDTH-1 -: SYS_DWIDTH] <= data_i;
        2'd1:    r_partial[2*SYS_DWIDTH-1 -: SYS_DWIDTH] <= data_i;
        default: r_partial[SYS_DWIDTH-1 -: SYS_DWIDTH]   <= data_i;
      endcase
      r_idx <= r_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (clr_i) begin
      r_overflow <= 1'b0;
    end else if (w_push && !w_accept) begin
      r_overflow <= 1'b1;
    end
  end

`ifdef PLAINTEXT_PACKER_MSG_CNT_EN
  logic [15:0] r_msg_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_msg_cnt <= '0;
    end else if (clr_i) begin
      r_msg_cnt <= '0;
    end else if (w_accept && w_push_entry.last) begin
      r_msg_cnt <= r_msg_cnt + 16'd1;
    end
  end

  assign msg_cnt_o = r_msg_cnt;
`endif

  packer_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr_i),
    .push_i  (w_accept),
    .pop_i   (w_pop),
    .wdata_i (w_push_entry),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (level_o)
  );

  assign valid_o    = !w_empty;
  assign data_o     = w_head.data;
  assign be_o       = w_head.be;
  assign last_o     = w_head.last;
  assign overflow_o = r_overflow;

endmodule

// File: tb/tb_plaintext_packer.sv
// -----------------------------------------------------------------------------
// tb_plaintext_packer
// Directed and random stimulus for plaintext_packer against a queue-based
// reference model: the current message is a list of bytes, the FIFO is a
// bounded queue of expected words. Define PLAINTEXT_PACKER_MSG_CNT_EN to
// also check msg_cnt_o.
// -----------------------------------------------------------------------------
module tb_plaintext_packer;

  localparam int         DEPTH = 8;
  localparam logic [7:0] TERM  = 8'hFA;

  logic        clk;
  logic        rst_n;
  logic        clr_i;
  logic [7:0]  data_i;
  logic        valid_i;
  logic [31:0] data_o;
  logic [3:0]  be_o;
  logic        last_o;
  logic        valid_o;
  logic        ready_i;
  logic [3:0]  level_o;
  logic        overflow_o;
`ifdef PLAINTEXT_PACKER_MSG_CNT_EN
  logic [15:0] msg_cnt_o;
`endif

  plaintext_packer #(
    .SYS_DWIDTH (8),
    .MST_DWIDTH (32),
    .FIFO_DEPTH (DEPTH),
    .TERM_CHAR  (TERM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .data_o     (data_o),
    .be_o       (be_o),
    .last_o     (last_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .level_o    (level_o),
    .overflow_o (overflow_o)
`ifdef PLAINTEXT_PACKER_MSG_CNT_EN
    ,
    .msg_cnt_o  (msg_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  be;
    logic        last;
  } word_t;

  word_t       m_q[$];
  logic [7:0]  m_cur[$];
  logic        m_ovf;
  int unsigned m_cnt;
  int          n_checks;
  int          n_fail;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_cur.delete();
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  function automatic word_t make_word(input logic last);
    word_t w;
    w.data = '0;
    w.be   = '0;
    w.last = last;
    for (int i = 0; i < m_cur.size(); i++) begin
      w.data[31-8*i -: 8] = m_cur[i];
      w.be[3-i]           = 1'b1;
    end
    return w;
  endfunction

  // One clock edge of the reference: pop first, then the new word may use
  // the freed slot.
  task automatic model_edge(input logic c, input logic v, input logic [7:0] d, input logic r);
    word_t w;
    bit    have;
    if (c) begin
      model_clear();
      return;
    end
    if (m_q.size() > 0 && r) void'(m_q.pop_front());
    have = 0;
    if (v) begin
      if (d == TERM) begin
        w    = make_word(1'b1);
        have = 1;
      end else begin
        m_cur.push_back(d);
        if (m_cur.size() == 4) begin
          w    = make_word(1'b0);
          have = 1;
        end
      end
    end
    if (have) begin
      m_cur.delete();
      if (m_q.size() < DEPTH) begin
        m_q.push_back(w);
        if (w.last) m_cnt = (m_cnt + 1) & 32'hFFFF;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    word_t h;
    bit    has;
    has = (m_q.size() > 0);
    if (has) h = m_q[0];
    else     h = '{data: 32'h0, be: 4'h0, last: 1'b0};
    check("valid_o",    64'(valid_o),    64'(has));
    check("data_o",     64'(data_o),     64'(h.data));
    check("be_o",       64'(be_o),       64'(h.be));
    check("last_o",     64'(last_o),     64'(h.last));
    check("level_o",    64'(level_o),    64'(m_q.size()));
    check("overflow_o", 64'(overflow_o), 64'(m_ovf));
`ifdef PLAINTEXT_PACKER_MSG_CNT_EN
    check("msg_cnt_o",  64'(msg_cnt_o),  64'(m_cnt));
`endif
  endtask

  // Drive after a falling edge, update the model at the rising edge, sample 1ns later.
  task automatic step(input logic c, input logic v, input logic [7:0] d, input logic r);
    clr_i   = c;
    valid_i = v;
    data_i  = d;
    ready_i = r;
    @(posedge clk);
    model_edge(c, v, d, r);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic async_reset_check();
    rst_n = 1'b0;
    #2;
    check("rst_valid_o",  64'(valid_o),    64'd0);
    check("rst_data_o",   64'(data_o),     64'd0);
    check("rst_be_o",     64'(be_o),       64'd0);
    check("rst_last_o",   64'(last_o),     64'd0);
    check("rst_level_o",  64'(level_o),    64'd0);
    check("rst_overflow", 64'(overflow_o), 64'd0);
    model_clear();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_w;
    logic        c;
    logic        v;
    logic        r;
    logic [7:0]  d;

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    clr_i    = 1'b0;
    valid_i  = 1'b0;
    data_i   = 8'h00;
    ready_i  = 1'b0;
    model_clear();
    #2;
    rst_n = 1'b0;
    #10;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Full word 41 42 43 44.
    step(0, 1, 8'h41, 1);
    step(0, 1, 8'h42, 1);
    step(0, 1, 8'h43, 1);
    step(0, 1, 8'h44, 1);
    check("word_full_data", 64'(data_o), 64'h41424344);
    check("word_full_be",   64'(be_o),   64'hF);
    check("word_full_last", 64'(last_o), 64'd0);
    step(0, 0, 8'h00, 1);

    // Partial word flushed by terminator.
    step(0, 1, 8'h61, 1);
    step(0, 1, 8'h62, 1);
    step(0, 1, TERM,  1);
    check("flush_data", 64'(data_o), 64'h61620000);
    check("flush_be",   64'(be_o),   64'hC);
    check("flush_last", 64'(last_o), 64'd1);
    step(0, 0, 8'h00, 1);

    // Terminator at a word boundary gives an empty last word.
    step(0, 1, TERM, 1);
    check("empty_valid", 64'(valid_o), 64'd1);
    check("empty_data",  64'(data_o),  64'd0);
    check("empty_be",    64'(be_o),    64'd0);
    check("empty_last",  64'(last_o),  64'd1);
`ifdef PLAINTEXT_PACKER_MSG_CNT_EN
    check("two_msgs", 64'(msg_cnt_o), 64'd2);
`endif
    step(0, 0, 8'h00, 1);

    // Nine words into a depth-8 FIFO with the consumer stalled.
    for (int w = 0; w < 9; w++)
      for (int b = 0; b < 4; b++)
        step(0, 1, 8'(4 * w + b + 1), 0);
    check("ovf_level", 64'(level_o),    64'd8);
    check("ovf_flag",  64'(overflow_o), 64'd1);
    for (int w = 0; w < 8; w++) begin
      exp_w = {8'(4 * w + 1), 8'(4 * w + 2), 8'(4 * w + 3), 8'(4 * w + 4)};
      check("drain_order", 64'(data_o), 64'(exp_w));
      step(0, 0, 8'h00, 1);
    end
    check("drain_empty", 64'(valid_o), 64'd0);

    // Full FIFO with push and pop on the same edge.
    step(1, 0, 8'h00, 0);
    check("clr_ovf", 64'(overflow_o), 64'd0);
    for (int i = 0; i < 32; i++) step(0, 1, 8'(i + 8'h80), 0);
    step(0, 1, 8'h01, 0);
    step(0, 1, 8'h02, 0);
    step(0, 1, 8'h03, 0);
    step(0, 1, 8'h04, 1);
    check("pushpop_level", 64'(level_o),    64'd8);
    check("pushpop_ovf",   64'(overflow_o), 64'd0);
    step(1, 0, 8'h00, 0);

    // Clear mid-word discards the partial word and the byte in that cycle.
    step(0, 1, 8'h01, 1);
    step(0, 1, 8'h02, 1);
    step(1, 1, 8'h03, 1);
    step(0, 1, 8'h11, 1);
    step(0, 1, 8'h22, 1);
    step(0, 1, 8'h33, 1);
    step(0, 1, 8'h44, 1);
    check("clr_word_data", 64'(data_o), 64'h11223344);
    check("clr_word_be",   64'(be_o),   64'hF);
    step(0, 0, 8'h00, 1);

    // Sustained bytes with ready held high: never overflows.
    for (int i = 0; i < 600; i++) begin
      d = ($urandom_range(9, 0) == 0) ? TERM : 8'($urandom_range(255, 0));
      step(0, 1, d, 1);
    end
    check("sustain_no_ovf", 64'(overflow_o), 64'd0);

    // Random traffic with occasional clears and one asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) async_reset_check();
      c = ($urandom_range(199, 0) == 0);
      v = ($urandom_range(3, 0) != 0);
      d = ($urandom_range(7, 0) == 0) ? TERM : 8'($urandom_range(255, 0));
      r = ($urandom_range(2, 0) != 0);
      step(c, v, d, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
